regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised multi-read-port integer register file with an integrated busy scoreboard, replacing the fixed 32x32 two-read-port register file for the pipelined core. It sits between decode, which issues and reads operands, and writeback. Each register carries a busy bit that is set when an instruction targeting it issues and cleared when its result is written back, so decode can stall on RAW hazards. An optional write-to-read bypass is provided.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of independent read ports (1..4)
ZERO_REG, 1, if 1 register 0 is hardwired to zero and never busy; if 0 register 0 is an ordinary register
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NRD  busy bit of register addressed by port k
wr_en  in  1  writeback write enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
iss_en  in  1  an instruction with destination iss_addr issues this cycle
iss_addr  in  AW  destination register of the issuing instruction
flush  in  1  synchronous clear of all busy bits (pipeline flush); register contents unaffected
busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. rd_data reflects zeroed registers; rd_busy = 0. Reset asserted mid-operation discards any in-flight write or issue that cycle.
- Reads are combinational: rd_data[k] = reg[rd_addr[k]], rd_busy[k] = busy[rd_addr[k]]. Zero read latency.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. One write port only.
- Issue: on a rising edge with iss_en=1, busy[iss_addr] <= 1.
- Simultaneous issue and write to the same address: busy ends at 1 (the new issue wins); data is still written.
- flush=1: all busy bits cleared at the edge, overriding an issue in the same cycle. A write in the same cycle still updates data.
- ZERO_REG=1: writes to address 0 are ignored, issue to address 0 is ignored, reads of 0 return 0 and busy 0.
- busy_cnt equals the popcount of the registered busy vector. It is updated in the same edge as the busy bits, computed from next-state busy bits, never underflows, and has a maximum of NREGS (or NREGS-1 with ZERO_REG=1).
- Multiple read ports addressing the same register each return identical values.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: if wr_en=1 and rd_addr[k]==wr_addr (excluding address 0 when ZERO_REG=1), rd_data[k] returns wr_data and rd_busy[k] returns 0 in the same cycle, unless iss_en=1 to the same address in that cycle, in which case rd_busy[k]=1.
- Not defined: reads return pre-edge contents; a written value is visible from the cycle after the edge.

Decomposition:
- Shared package regfile_pkg: XLEN/NREGS defaults, AW derivation function, and an address-zero constant.
- One natural sub-module, regfile_scoreboard: holds the busy vector with issue/write/flush priority logic and busy_cnt. The top holds the data array, read muxes and bypass.

Test Plan:
1. Reset, then write 0xDEADBEEF to x5; next cycle read x5 on both ports -> both rd_data = 0xDEADBEEF, rd_busy = 0.
2. Issue x7 -> rd_busy = 1, busy_cnt = 1. Write x7 = 0x12 two cycles later -> busy 0, busy_cnt 0, data 0x12.
3. Same cycle iss_en and wr_en to x9 with data 0x55 -> after edge, busy[x9] = 1, reg x9 = 0x55, busy_cnt = 1.
4. Write 0xFFFFFFFF to x0 and issue x0 (ZERO_REG=1) -> read x0 = 0, busy 0, busy_cnt unchanged.
5. Issue x1, x2, x3, then assert flush together with iss x4 -> all busy = 0, busy_cnt = 0. Register values are unchanged.
6. With REGFILE_SB_BYPASS_EN defined, write x10 = 0xA5A5A5A5 while port 1 reads x10 -> rd_data[1] = 0xA5A5A5A5 in the same cycle. Without the macro the same stimulus shows the old value. Also assert rst mid-write -> x10 = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the regfile_sb register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_ADDR = 0;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy vector for RAW hazard tracking: write clears, issue sets (issue wins), flush clears all.
// Also keeps busy_cnt as the popcount of the next-state busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == AW'(ZERO_ADDR));
  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == AW'(ZERO_ADDR));

  // Priority low to high: write clear, issue set, flush clear.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wr_addr]  = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    if (flush)  busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward the writeback value to same-cycle reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == AW'(ZERO_ADDR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .flush   (flush),
    .busy    (busy),
    .busy_cnt(busy_cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
      // Forwarded value is fresh, so not busy unless re-issued this same cycle.
      if (wr_ok && addr == wr_addr) begin
        data = wr_data;
        bsy  = iss_en && (iss_addr == addr);
      end
`endif
      if (ZERO_REG != 0 && addr == AW'(ZERO_ADDR)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = bsy;
  end

endmodule
